// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 5-port mesh router: XY route codes, port index
// constants, and helpers that decode a route code to a port index.
// Used by the route-computation block and by xy_switch_allocator.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NPORT = 5;  // router ports: local, south, west, east, north
    localparam int IDXW  = 3;  // width of a port index
    localparam int CODEW = 4;  // width of an XY route code

    // Route codes produced by XY routing (zero-hot or one-hot)
    localparam logic [CODEW-1:0] PORT_LOCAL = 4'b0000;
    localparam logic [CODEW-1:0] PORT_SOUTH = 4'b0001;
    localparam logic [CODEW-1:0] PORT_WEST  = 4'b0010;
    localparam logic [CODEW-1:0] PORT_EAST  = 4'b0100;
    localparam logic [CODEW-1:0] PORT_NORTH = 4'b1000;

    // Port indices, shared by inputs and outputs
    localparam logic [IDXW-1:0] IDX_LOCAL = 3'd0;
    localparam logic [IDXW-1:0] IDX_SOUTH = 3'd1;
    localparam logic [IDXW-1:0] IDX_WEST  = 3'd2;
    localparam logic [IDXW-1:0] IDX_EAST  = 3'd3;
    localparam logic [IDXW-1:0] IDX_NORTH = 3'd4;

    // A code is legal when at most one bit is set.
    function automatic logic code_legal(input logic [CODEW-1:0] code);
        return (code & (code - 4'd1)) == 4'd0;
    endfunction

    // Decode a legal route code to its output index. Illegal codes map to
    // local; callers must qualify with code_legal().
    function automatic logic [IDXW-1:0] code_to_idx(input logic [CODEW-1:0] code);
        case (code)
            PORT_SOUTH: return IDX_SOUTH;
            PORT_WEST:  return IDX_WEST;
            PORT_EAST:  return IDX_EAST;
            PORT_NORTH: return IDX_NORTH;
            default:    return IDX_LOCAL;
        endcase
    endfunction

    // Reduce a small non-negative integer modulo NPORT to a port index.
    function automatic logic [IDXW-1:0] wrap_idx(input int v);
        return IDXW'(v % NPORT);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// -----------------------------------------------------------------------------
// rr_arbiter5
// Purely combinational 5-request round-robin picker. The search starts at
// ptr_i+1 and walks upward, wrapping 4 -> 0, so the input named by ptr_i has
// the lowest priority.
//   req_i  [4:0] : request vector
//   ptr_i  [2:0] : index of the most recent winner
//   gnt_o  [4:0] : one-hot grant (all zero when no request)
//   idx_o  [2:0] : index of the granted request (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter5 import router_pkg::*; (
    input  logic [NPORT-1:0] req_i,
    input  logic [IDXW-1:0]  ptr_i,
    output logic [NPORT-1:0] gnt_o,
    output logic [IDXW-1:0]  idx_o
);

    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = wrap_idx(int'(ptr_i) + k);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/xy_switch_allocator.sv
// -----------------------------------------------------------------------------
// xy_switch_allocator
// Output-port allocator for a 5-port wormhole mesh router. Each output runs an
// IDLE/LOCKED FSM: in IDLE it picks a requester round-robin and locks to it;
// in LOCKED it passes that input's flits whenever the input is valid and the
// downstream is ready, and unlocks on the tail transfer.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  [4:0]  : per input, a flit is waiting
//   req_port   [19:0] : per input i, bits [4i+3:4i], XY route code
//   req_tail   [4:0]  : per input, the waiting flit is a tail
//   out_ready  [4:0]  : per output, downstream accepts a flit this cycle
//   grant      [4:0]  : per input, flit transfers this cycle
//   out_valid  [4:0]  : per output, a flit is driven this cycle
//   out_sel    [14:0] : per output o, bits [3o+2:3o], driving input index
//   route_err  [4:0]  : per input, sticky flag for an illegal route code
// -----------------------------------------------------------------------------
module xy_switch_allocator import router_pkg::*; (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        req_valid,
    input  logic [NPORT*CODEW-1:0]  req_port,
    input  logic [NPORT-1:0]        req_tail,
    input  logic [NPORT-1:0]        out_ready,
    output logic [NPORT-1:0]        grant,
    output logic [NPORT-1:0]        out_valid,
    output logic [NPORT*IDXW-1:0]   out_sel,
    output logic [NPORT-1:0]        route_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Per-output state
    logic [NPORT-1:0]           state_q, state_d;
    logic [NPORT-1:0][IDXW-1:0] owner_q, owner_d;
    logic [NPORT-1:0][IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NPORT-1:0]           route_err_q, route_err_d;

    // Per-input decode
    logic [NPORT-1:0]           legal;
    logic [NPORT-1:0][IDXW-1:0] dest;

    // cand[o][i]: input i is a legal, valid request for output o
    logic [NPORT-1:0][NPORT-1:0] cand;
    logic [NPORT-1:0][NPORT-1:0] win_gnt;
    logic [NPORT-1:0][IDXW-1:0]  win_idx;

    always_comb begin
        legal = '0;
        dest  = '0;
        for (int i = 0; i < NPORT; i++) begin
            legal[i] = code_legal(req_port[CODEW*i +: CODEW]);
            dest[i]  = code_to_idx(req_port[CODEW*i +: CODEW]);
        end
    end

    always_comb begin
        cand = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = req_valid[i] & legal[i] & (dest[i] == IDXW'(o));
            end
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_arb
        rr_arbiter5 u_arb (
            .req_i (cand[g]),
            .ptr_i (rr_ptr_q[g]),
            .gnt_o (win_gnt[g]),
            .idx_o (win_idx[g])
        );
    end

    // Crossbar control: owner is driven on out_sel at all times (0 while
    // IDLE because owner is cleared on unlock); a transfer needs the owner
    // valid and the downstream ready in the same cycle.
    always_comb begin
        grant     = '0;
        out_valid = '0;
        out_sel   = '0;
        for (int o = 0; o < NPORT; o++) begin
            out_sel[IDXW*o +: IDXW] = owner_q[o];
            if (state_q[o] == ST_LOCKED) begin
                out_valid[o] = req_valid[owner_q[o]] & out_ready[o];
                if (out_valid[o]) begin
                    grant[owner_q[o]] = 1'b1;
                end
            end
        end
    end

    // Lock/unlock. Requests are only examined in IDLE, so a request arriving
    // alongside a tail transfer waits for the following IDLE cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        for (int o = 0; o < NPORT; o++) begin
            case (state_q[o])
                ST_IDLE: begin
                    if (|win_gnt[o]) begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = win_idx[o];
                    end
                end
                default: begin
                    if (out_valid[o] && req_tail[owner_q[o]]) begin
                        state_d[o]  = ST_IDLE;
                        owner_d[o]  = '0;
                        rr_ptr_d[o] = owner_q[o];
                    end
                end
            endcase
        end
        route_err_d = route_err_q | (req_valid & ~legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= {NPORT{ST_IDLE}};
            owner_q     <= '0;
            // Pointer at the top index gives input 0 first priority.
            rr_ptr_q    <= {NPORT{IDX_NORTH}};
            route_err_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples its pre-edge value, independent of block order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            route_err_q <= route_err_d;
        end
    end

    assign route_err = route_err_q;

endmodule

// File: tb/tb_xy_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_xy_switch_allocator
// Self-checking bench for xy_switch_allocator. Each send() pushes the expected
// input index for every flit onto a per-output queue; each sampled cycle pops
// and compares against out_valid/out_sel/grant. Scenario tasks add inline
// timing checks.
// -----------------------------------------------------------------------------
module tb_xy_switch_allocator;

    localparam int NP = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [19:0] req_port;
    logic [4:0]  req_tail;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [4:0]  route_err;

    int checks = 0;
    int errors = 0;
    int sample = 0;

    int left      [NP];
    int first_gnt [NP];
    int last_gnt  [NP];
    int sb        [NP][$];

    logic [4:0]  g_obs, v_obs, e_obs;
    logic [14:0] s_obs;

    always #5 clk = ~clk;

    xy_switch_allocator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_port  (req_port),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .route_err (route_err)
    );

    function automatic bit busy();
        for (int i = 0; i < NP; i++) if (left[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Start a packet of n flits on input i, expected on output dest.
    task automatic send(input int i, input logic [3:0] code, input int dest, input int n);
        req_port[4*i +: 4] = code;
        req_tail[i]        = (n == 1);
        req_valid[i]       = 1'b1;
        left[i]            = n;
        first_gnt[i]       = -1;
        last_gnt[i]        = -1;
        for (int k = 0; k < n; k++) sb[dest].push_back(i);
    endtask

    // One clock: sample at negedge, score transfers, advance the flit sources
    // just after the following posedge.
    task automatic cycle();
        int exp_in;
        @(negedge clk);
        sample++;
        g_obs = grant;
        v_obs = out_valid;
        s_obs = out_sel;
        e_obs = route_err;
        for (int o = 0; o < NP; o++) begin
            if (v_obs[o]) begin
                checks++;
                if (sb[o].size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected out=%0d got sel=%0d want no transfer", o, s_obs[3*o +: 3]);
                end else begin
                    exp_in = sb[o].pop_front();
                    if (s_obs[3*o +: 3] !== 3'(exp_in) || g_obs[exp_in] !== 1'b1) begin
                        errors++;
                        $display("FAIL sb_transfer out=%0d got sel=%0d grant=%b want sel=%0d", o, s_obs[3*o +: 3], g_obs, exp_in);
                    end
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (g_obs[i]) begin
                if (first_gnt[i] < 0) first_gnt[i] = sample;
                last_gnt[i] = sample;
                if (left[i] > 0) left[i]--;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (req_valid[i]) begin
                if (left[i] == 0) req_valid[i] = 1'b0;
                req_tail[i] = (left[i] == 1);
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (busy() && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL %s_timeout got flits pending after %0d cycles want none", name, budget);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (grant !== 5'b0)      begin errors++; $display("FAIL reset_grant got %b want 00000", grant); end
        checks++; if (out_valid !== 5'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 00000", out_valid); end
        checks++; if (out_sel !== 15'b0)   begin errors++; $display("FAIL reset_out_sel got %h want 0", out_sel); end
        checks++; if (route_err !== 5'b0)  begin errors++; $display("FAIL reset_route_err got %b want 00000", route_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_local();
        int s0;
        out_ready = 5'b11111;
        s0 = sample;
        send(0, 4'b0100, 3, 1);
        cycle();
        checks++; if (g_obs !== 5'b00000) begin errors++; $display("FAIL single_c1_grant got %b want 00000", g_obs); end
        cycle();
        checks++; if (g_obs !== 5'b00001) begin errors++; $display("FAIL single_c2_grant got %b want 00001", g_obs); end
        checks++; if (v_obs !== 5'b01000) begin errors++; $display("FAIL single_c2_out_valid got %b want 01000", v_obs); end
        checks++; if (s_obs[11:9] !== 3'd0) begin errors++; $display("FAIL single_c2_out_sel got %0d want 0", s_obs[11:9]); end
        cycle();
        checks++; if (v_obs !== 5'b00000) begin errors++; $display("FAIL single_c3_out_valid got %b want 00000", v_obs); end
        checks++; if (first_gnt[0] !== s0 + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", first_gnt[0], s0 + 2); end
    endtask

    task automatic test_contention();
        int s0;
        for (int rep = 0; rep < 2; rep++) begin
            s0 = sample;
            send(1, 4'b0000, 0, 1);
            send(2, 4'b0000, 0, 1);
            send(4, 4'b0000, 0, 1);
            drain("contention", 20);
            checks++; if (first_gnt[1] !== s0 + 2) begin errors++; $display("FAIL contention_in1 rep=%0d got %0d want %0d", rep, first_gnt[1], s0 + 2); end
            checks++; if (first_gnt[2] !== s0 + 4) begin errors++; $display("FAIL contention_in2 rep=%0d got %0d want %0d", rep, first_gnt[2], s0 + 4); end
            checks++; if (first_gnt[4] !== s0 + 6) begin errors++; $display("FAIL contention_in4 rep=%0d got %0d want %0d", rep, first_gnt[4], s0 + 6); end
        end
    endtask

    task automatic test_wormhole();
        int s0;
        s0 = sample;
        send(3, 4'b1000, 4, 3);
        cycle();
        send(0, 4'b1000, 4, 1);
        drain("wormhole", 20);
        checks++; if (first_gnt[3] !== s0 + 2) begin errors++; $display("FAIL wormhole_head got %0d want %0d", first_gnt[3], s0 + 2); end
        checks++; if (last_gnt[3] !== s0 + 4)  begin errors++; $display("FAIL wormhole_tail got %0d want %0d", last_gnt[3], s0 + 4); end
        checks++; if (first_gnt[0] !== s0 + 6) begin errors++; $display("FAIL wormhole_waiter got %0d want %0d", first_gnt[0], s0 + 6); end
    endtask

    task automatic test_backpressure();
        int s0;
        int r;
        s0 = sample;
        send(2, 4'b0001, 1, 4);
        cycle();
        cycle();
        checks++; if (first_gnt[2] !== s0 + 2) begin errors++; $display("FAIL bp_head got %0d want %0d", first_gnt[2], s0 + 2); end
        out_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (g_obs[2] !== 1'b0) begin errors++; $display("FAIL bp_stall_grant k=%0d got %b want 0", k, g_obs[2]); end
            checks++; if (v_obs[1] !== 1'b0) begin errors++; $display("FAIL bp_stall_valid k=%0d got %b want 0", k, v_obs[1]); end
            checks++; if (s_obs[5:3] !== 3'd2) begin errors++; $display("FAIL bp_stall_sel k=%0d got %0d want 2", k, s_obs[5:3]); end
        end
        out_ready[1] = 1'b1;
        cycle();
        checks++; if (g_obs !== 5'b00100) begin errors++; $display("FAIL bp_resume got %b want 00100", g_obs); end
        req_valid[2] = 1'b0;
        cycle();
        checks++; if (g_obs !== 5'b00000) begin errors++; $display("FAIL bp_owner_idle_grant got %b want 00000", g_obs); end
        checks++; if (s_obs[5:3] !== 3'd2) begin errors++; $display("FAIL bp_owner_idle_sel got %0d want 2", s_obs[5:3]); end
        req_valid[2] = 1'b1;
        r = sample;
        drain("backpressure", 20);
        checks++; if (last_gnt[2] !== r + 2) begin errors++; $display("FAIL bp_tail got %0d want %0d", last_gnt[2], r + 2); end
    endtask

    task automatic test_illegal();
        req_port[7:4] = 4'b0110;
        req_tail[1]   = 1'b1;
        req_valid[1]  = 1'b1;
        left[1]       = 1;
        first_gnt[1]  = -1;
        cycle();
        checks++; if (g_obs !== 5'b00000) begin errors++; $display("FAIL illegal_c1_grant got %b want 00000", g_obs); end
        checks++; if (e_obs !== 5'b00000) begin errors++; $display("FAIL illegal_c1_err got %b want 00000", e_obs); end
        cycle();
        checks++; if (g_obs !== 5'b00000) begin errors++; $display("FAIL illegal_c2_grant got %b want 00000", g_obs); end
        checks++; if (e_obs !== 5'b00010) begin errors++; $display("FAIL illegal_c2_err got %b want 00010", e_obs); end
        req_valid[1] = 1'b0;
        left[1]      = 0;
        cycle();
        checks++; if (e_obs !== 5'b00010) begin errors++; $display("FAIL illegal_sticky got %b want 00010", e_obs); end
        rst_n = 1'b0;
        #2;
        checks++; if (route_err !== 5'b00000) begin errors++; $display("FAIL illegal_reset_clear got %b want 00000", route_err); end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int s0;
        send(2, 4'b0100, 3, 4);
        cycle();
        cycle();
        #2;
        checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL areset_pre_grant got %b want 00100", grant); end
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 5'b0)     begin errors++; $display("FAIL areset_grant got %b want 00000", grant); end
        checks++; if (out_valid !== 5'b0) begin errors++; $display("FAIL areset_out_valid got %b want 00000", out_valid); end
        checks++; if (out_sel !== 15'b0)  begin errors++; $display("FAIL areset_out_sel got %h want 0", out_sel); end
        req_valid = '0;
        left[2]   = 0;
        sb[3].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s0 = sample;
        send(1, 4'b0100, 3, 1);
        cycle();
        checks++; if (g_obs !== 5'b00000) begin errors++; $display("FAIL areset_new_c1 got %b want 00000", g_obs); end
        cycle();
        checks++; if (g_obs !== 5'b00010) begin errors++; $display("FAIL areset_new_c2 got %b want 00010", g_obs); end
        checks++; if (s_obs[11:9] !== 3'd1) begin errors++; $display("FAIL areset_new_sel got %0d want 1", s_obs[11:9]); end
        drain("areset", 10);
        checks++; if (first_gnt[1] !== s0 + 2) begin errors++; $display("FAIL areset_latency got %0d want %0d", first_gnt[1], s0 + 2); end
    endtask

    initial begin
        int pending;
        rst_n     = 1'b0;
        req_valid = '0;
        req_port  = '0;
        req_tail  = '0;
        out_ready = '0;
        for (int i = 0; i < NP; i++) begin
            left[i]      = 0;
            first_gnt[i] = -1;
            last_gnt[i]  = -1;
        end
        test_reset();
        test_single_local();
        test_contention();
        test_wormhole();
        test_backpressure();
        test_illegal();
        test_async_reset();
        pending = 0;
        for (int o = 0; o < NP; o++) pending += sb[o].size();
        checks++;
        if (pending != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d expected transfers never seen want 0", pending);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish by 200000 want earlier finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xy_switch_allocator.md
Name: xy_switch_allocator

Overview:
- Output-port allocator for one 5-port mesh router. It sits between the per-input XY route computation and the crossbar.
- Each input presents the 4-bit port code from XY routing. The block arbitrates, round-robin, among inputs contending for each output.
- Once a head flit wins an output, that output stays locked to the winner until the tail flit transfers (wormhole switching).

Parameters:
- NPORT, 5, number of router ports; fixed at 5 for the mesh router.
- IDXW, 3, width of a port index.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  5  per input: a flit is waiting
- req_port  in  20  per input i, bits [4i+3:4i]: route code. 0000 local, 0001 south, 0010 west, 0100 east, 1000 north
- req_tail  in  5  per input: the waiting flit is a tail (single-flit packet has head = tail)
- out_ready  in  5  per output: downstream can accept a flit this cycle
- grant  out  5  per input: flit transfers this cycle
- out_valid  out  5  per output: a flit is driven this cycle
- out_sel  out  15  per output o, bits [3o+2:3o]: index of the driving input
- route_err  out  5  per input, sticky: an illegal route code was seen

Behaviour:
- Index map, inputs and outputs alike: 0 local, 1 south, 2 west, 3 east, 4 north.
  - Code to output index: 0000→0, 0001→1, 0010→2, 0100→3, 1000→4.
- Legal codes are zero-hot or one-hot only. Any other code:
  - the request is ignored;
  - route_err[i] is set on the next edge and holds until reset.
- Per output o, a two-state FSM: IDLE / LOCKED. Registered state per output: owner[o] (3b) and rr_ptr[o] (3b).
- IDLE → LOCKED:
  - Candidates are inputs with req_valid and a legal code decoding to o.
  - The winner is the first candidate searching upward from rr_ptr[o]+1, wrapping 4→0.
  - owner[o] ← winner at the next edge. out_ready is irrelevant to locking.
- In LOCKED:
  - grant[owner] = out_valid[o] = req_valid[owner] & out_ready[o], combinational.
  - out_sel[o] = owner at all times; it is 0 while IDLE.
- Transfer with req_tail[owner]=1: LOCKED → IDLE and rr_ptr[o] ← owner at the same edge. The output can re-lock on the following cycle.
- Latency: a head flit is granted no earlier than 1 cycle after it first requests. Body flits can transfer every cycle.
- Owner drops req_valid mid-packet: the lock is held and no grant is given; other requesters wait.
- The requester holds req_port stable from head to tail. The allocator does not re-decode while LOCKED.
- An input owns at most one output, since its code names one output. grant has at most one bit per input.
- Reset, including mid-packet:
  - all FSMs IDLE; owner = 0; rr_ptr = 4, so input 0 has first priority;
  - route_err = 0; grant, out_valid and out_sel are 0 while rst_n is low.
- Simultaneous tail and new request on the same output: the new request waits for the IDLE cycle.

Decomposition:
- Shared package router_pkg:
  - port code localparams PORT_LOCAL, PORT_SOUTH, PORT_WEST, PORT_EAST, PORT_NORTH;
  - index constants IDX_LOCAL .. IDX_NORTH;
  - NPORT;
  - the code-to-index decode function. The route block uses the same package.
- Sub-module rr_arbiter5: a 5-request round-robin picker taking a pointer, returning a one-hot grant and an index. It is instantiated once per output.

Test Plan:
- Single local packet: after reset, input 0 sends a 1-flit tail with code 0100 and out_ready=11111.
  - Cycle 1: no grant.
  - Cycle 2: grant=00001, out_valid[3]=1, out_sel[3]=0.
  - Cycle 3: output 3 IDLE.
- Contention: inputs 1, 2 and 4 all send 1-flit packets with code 0000 in the same cycle.
  - Grants to output 0 go in order 1, 2, 4, one packet per 2 cycles.
  - Repeat the same traffic: order is again 1, 2, 4, since rr_ptr=4 wraps.
- Wormhole hold: input 3 sends a 3-flit packet to code 1000 while input 0 also requests 1000 from the head cycle onward.
  - Input 0 receives no grant until 1 cycle after input 3's tail transfers.
- Backpressure: locked input 2 → output 1, out_ready[1]=0 for 3 cycles.
  - grant[2]=0 and out_valid[1]=0 during those cycles; the state stays LOCKED.
  - Flits resume when out_ready returns.
- Illegal code: input 1 sends code 0110.
  - No grant; route_err=00010 from the next cycle, sticky.
  - rst_n pulsed low clears it.
- Async reset mid-packet: rst_n drops between clock edges while output 3 is LOCKED.
  - grant, out_valid and out_sel go to 0 immediately.
  - After release, a new head gets its grant 1 cycle after requesting.
